// File: rtl/apb_irq_event_ctrl.sv
// apb_irq_event_ctrl
//   APB-programmable interrupt/event controller sitting in front of the core
//   sleep unit. 32 interrupt sources and 32 event sources are rising-edge
//   detected into pending registers. Masked interrupt pending bits drive one
//   prioritised request (lowest index wins) with an ID/ack handshake. Masked
//   event pending bits drive a registered event level.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE/PRDATA/PREADY/PSLVERR
//                        APB slave, zero wait states, PADDR[4:2] selects a register
//   irq_sources_i        interrupt sources (synchronous to HCLK)
//   event_sources_i      event sources (synchronous to HCLK)
//   irq_ack_i, irq_id_i  core acknowledge and the ID being acknowledged
//   irq_o, irq_id_o      request and ID of the requested interrupt
//   event_o              event level to the sleep unit
//   irq_state_o          debug view of the request FSM state (0 IDLE, 1 REQ, 2 ACKED)
//
// Handshake: irq_o rises with irq_id_o already valid and both stay stable
// until the core acks with a matching irq_id_i on a rising HCLK edge, or the
// request is withdrawn because its pending/mask bit went away. After an ack,
// irq_o stays low for at least two cycles.
module apb_irq_event_ctrl #(
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [31:0]               irq_sources_i,
  input  logic [31:0]               event_sources_i,
  input  logic                      irq_ack_i,
  input  logic [4:0]                irq_id_i,
  output logic                      irq_o,
  output logic [4:0]                irq_id_o,
  output logic                      event_o,
  output logic [1:0]                irq_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ACKED = 2'd2
  } irq_state_t;

  irq_state_t  state_q;
  logic [31:0] irq_mask_q, irq_pend_q, irq_prev_q;
  logic [31:0] evt_mask_q, evt_pend_q, evt_prev_q;
  logic [4:0]  irq_id_q;
  logic        event_q;

  // Only PADDR[4:2] decodes; the remaining address bits alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

  logic       apb_acc, apb_wr, apb_rd;
  logic [2:0] reg_sel;
  assign apb_acc = PSEL & PENABLE;
  assign apb_wr  = apb_acc & PWRITE;
  assign apb_rd  = apb_acc & ~PWRITE;
  assign reg_sel = PADDR[4:2];

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  logic [31:0] irq_rise, evt_rise;
  assign irq_rise = irq_sources_i & ~irq_prev_q;
  assign evt_rise = event_sources_i & ~evt_prev_q;

  logic [31:0] irq_sw_set, irq_sw_clr, evt_sw_set, evt_sw_clr;
  assign irq_sw_set = (apb_wr && reg_sel == 3'd1) ? PWDATA : 32'd0;
  assign irq_sw_clr = (apb_wr && reg_sel == 3'd2) ? PWDATA : 32'd0;
  assign evt_sw_set = (apb_wr && reg_sel == 3'd4) ? PWDATA : 32'd0;
  assign evt_sw_clr = (apb_wr && reg_sel == 3'd5) ? PWDATA : 32'd0;

  logic        ack_hit;
  logic [31:0] ack_clr;
  assign ack_hit = (state_q == S_REQ) && irq_ack_i && (irq_id_i == irq_id_q);
  assign ack_clr = ack_hit ? (32'd1 << irq_id_q) : 32'd0;

  // Set terms are ORed after the clear so a new edge is never lost.
  logic [31:0] irq_pend_n, evt_pend_n;
  assign irq_pend_n = (irq_pend_q & ~(irq_sw_clr | ack_clr)) | irq_rise | irq_sw_set;
  assign evt_pend_n = (evt_pend_q & ~evt_sw_clr) | evt_rise | evt_sw_set;

  logic [31:0] active;
  assign active = irq_pend_q & irq_mask_q;

  // Lowest set index wins: scan downwards so the last hit is the lowest.
  logic [4:0] prio_id;
  always_comb begin
    prio_id = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (active[i]) prio_id = i[4:0];
    end
  end

  always_comb begin
    PRDATA = 32'd0;
    if (apb_rd) begin
      case (reg_sel)
        3'd0:    PRDATA = irq_mask_q;
        3'd1:    PRDATA = irq_pend_q;
        3'd3:    PRDATA = evt_mask_q;
        3'd4:    PRDATA = evt_pend_q;
        default: PRDATA = 32'd0;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_mask_q <= 32'd0;
      irq_pend_q <= 32'd0;
      irq_prev_q <= 32'd0;
      evt_mask_q <= 32'd0;
      evt_pend_q <= 32'd0;
      evt_prev_q <= 32'd0;
      event_q    <= 1'b0;
    end else begin
      irq_prev_q <= irq_sources_i;
      evt_prev_q <= event_sources_i;
      irq_pend_q <= irq_pend_n;
      evt_pend_q <= evt_pend_n;
      if (apb_wr && reg_sel == 3'd0) irq_mask_q <= PWDATA;
      if (apb_wr && reg_sel == 3'd3) evt_mask_q <= PWDATA;
      event_q <= |(evt_pend_q & evt_mask_q);
    end
  end

  // Request FSM: the ID is latched on entry to REQ and never preempted.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      irq_id_q <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (active != 32'd0) begin
            state_q  <= S_REQ;
            irq_id_q <= prio_id;
          end
        end
        S_REQ: begin
          if (ack_hit)                state_q <= S_ACKED;
          else if (!active[irq_id_q]) state_q <= S_IDLE;
        end
        S_ACKED: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign irq_o       = (state_q == S_REQ);
  assign irq_id_o    = irq_id_q;
  assign event_o     = event_q;
  assign irq_state_o = state_q;

endmodule

// File: tb/tb_apb_irq_event_ctrl.sv
// Directed bench for apb_irq_event_ctrl. All stimulus changes and output
// samples happen 1 ns after a rising HCLK edge.
module tb_apb_irq_event_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] irq_sources_i = '0;
  logic [31:0] event_sources_i = '0;
  logic        irq_ack_i = 1'b0;
  logic [4:0]  irq_id_i = '0;
  logic        irq_o;
  logic [4:0]  irq_id_o;
  logic        event_o;
  logic [1:0]  irq_state_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  localparam logic [11:0] A_IRQ_MASK = 12'h000;
  localparam logic [11:0] A_IRQ_PEND = 12'h004;
  localparam logic [11:0] A_IRQ_CLR  = 12'h008;
  localparam logic [11:0] A_EVT_MASK = 12'h00C;
  localparam logic [11:0] A_EVT_PEND = 12'h010;
  localparam logic [11:0] A_EVT_CLR  = 12'h014;
  localparam logic [11:0] A_RSVD     = 12'h018;

  // clock / reset
  always #5 HCLK = ~HCLK;

  apb_irq_event_ctrl #(.APB_ADDR_WIDTH(12)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .irq_sources_i(irq_sources_i), .event_sources_i(event_sources_i),
    .irq_ack_i(irq_ack_i), .irq_id_i(irq_id_i),
    .irq_o(irq_o), .irq_id_o(irq_id_o), .event_o(event_o),
    .irq_state_o(irq_state_o)
  );

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Setup cycle then access cycle; the write lands on the second edge.
  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    PADDR = addr; PWDATA = data; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    step(1);
    PENABLE = 1'b1;
    step(1);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] addr, output logic [31:0] data);
    PADDR = addr; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    step(1);
    PENABLE = 1'b1;
    #1 data = PRDATA;
    step(1);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic ack(input logic [4:0] id);
    irq_ack_i = 1'b1; irq_id_i = id;
    step(1);
    irq_ack_i = 1'b0; irq_id_i = 5'd0;
  endtask

  initial begin
    // reset
    step(3);
    chk("rst_irq_o", {31'd0, irq_o}, 32'd0);
    HRESETn = 1'b1;
    step(1);
    chk("rst_irq_id", {27'd0, irq_id_o}, 32'd0);
    chk("rst_event_o", {31'd0, event_o}, 32'd0);
    chk("rst_state", {30'd0, irq_state_o}, 32'd0);
    chk("pready", {31'd0, PREADY}, 32'd1);
    chk("pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("prdata_idle", PRDATA, 32'd0);
    apb_read(A_IRQ_PEND, rd); chk("rst_irq_pend", rd, 32'd0);

    // single source 4, masked in
    apb_write(A_IRQ_MASK, 32'h0000_0010);
    apb_read(A_IRQ_MASK, rd); chk("irq_mask_rb", rd, 32'h0000_0010);
    irq_sources_i[4] = 1'b1;
    step(1);
    irq_sources_i[4] = 1'b0;
    chk("t1_irq_o_one_edge", {31'd0, irq_o}, 32'd0);
    step(1);
    chk("t1_irq_o", {31'd0, irq_o}, 32'd1);
    chk("t1_irq_id", {27'd0, irq_id_o}, 32'd4);
    chk("t1_event_o", {31'd0, event_o}, 32'd0);
    apb_read(A_IRQ_PEND, rd); chk("t1_pend", rd, 32'h0000_0010);
    chk("t1_irq_o_held", {31'd0, irq_o}, 32'd1);
    ack(5'd4);
    chk("t1_irq_o_acked", {31'd0, irq_o}, 32'd0);
    apb_read(A_IRQ_PEND, rd); chk("t1_pend_cleared", rd, 32'd0);

    // priority between 7 and 3
    apb_write(A_IRQ_MASK, 32'hFFFF_FFFF);
    irq_sources_i = 32'h0000_0088;
    step(1);
    irq_sources_i = 32'd0;
    step(1);
    chk("t2_irq_o", {31'd0, irq_o}, 32'd1);
    chk("t2_irq_id3", {27'd0, irq_id_o}, 32'd3);
    ack(5'd3);
    chk("t2_gap1", {31'd0, irq_o}, 32'd0);
    chk("t2_state_acked", {30'd0, irq_state_o}, 32'd2);
    step(1);
    chk("t2_gap2", {31'd0, irq_o}, 32'd0);
    step(1);
    chk("t2_irq_o_again", {31'd0, irq_o}, 32'd1);
    chk("t2_irq_id7", {27'd0, irq_id_o}, 32'd7);
    ack(5'd7);
    apb_read(A_IRQ_PEND, rd); chk("t2_pend_empty", rd, 32'd0);
    chk("t2_irq_o_low", {31'd0, irq_o}, 32'd0);

    // mismatched ack ignored, then software withdraw
    irq_sources_i[5] = 1'b1;
    step(1);
    irq_sources_i[5] = 1'b0;
    step(1);
    chk("t3_irq_id5", {27'd0, irq_id_o}, 32'd5);
    ack(5'd6);
    chk("t3_bad_ack_irq_o", {31'd0, irq_o}, 32'd1);
    chk("t3_bad_ack_id", {27'd0, irq_id_o}, 32'd5);
    apb_write(A_IRQ_CLR, 32'h0000_0020);
    chk("t3_still_req", {31'd0, irq_o}, 32'd1);
    step(1);
    chk("t3_withdrawn", {31'd0, irq_o}, 32'd0);
    chk("t3_state_idle", {30'd0, irq_state_o}, 32'd0);

    // source 9 rises in the same cycle as a clear of bit 9
    PADDR = A_IRQ_CLR; PWDATA = 32'h0000_0200; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    step(1);
    PENABLE = 1'b1;
    irq_sources_i[9] = 1'b1;
    step(1);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    apb_read(A_IRQ_PEND, rd); chk("t4_set_beats_clear", rd, 32'h0000_0200);
    chk("t4_irq_id9", {27'd0, irq_id_o}, 32'd9);
    apb_write(A_IRQ_CLR, 32'h0000_0200);
    step(3);
    apb_read(A_IRQ_PEND, rd); chk("t4_no_retrigger", rd, 32'd0);
    chk("t4_irq_o_low", {31'd0, irq_o}, 32'd0);
    irq_sources_i[9] = 1'b0;

    // events
    apb_write(A_EVT_MASK, 32'h0000_0001);
    apb_write(A_EVT_PEND, 32'h0000_0001);
    chk("t5_evt_lag", {31'd0, event_o}, 32'd0);
    step(1);
    chk("t5_evt_high", {31'd0, event_o}, 32'd1);
    apb_write(A_EVT_CLR, 32'h0000_0001);
    chk("t5_evt_still_high", {31'd0, event_o}, 32'd1);
    step(1);
    chk("t5_evt_low", {31'd0, event_o}, 32'd0);
    event_sources_i[2] = 1'b1;
    step(1);
    event_sources_i[2] = 1'b0;
    apb_read(A_EVT_PEND, rd); chk("t5_evt_pend4", rd, 32'h0000_0004);
    chk("t5_evt_masked", {31'd0, event_o}, 32'd0);
    apb_read(A_EVT_CLR, rd); chk("t5_evt_clr_reads0", rd, 32'd0);
    apb_write(A_RSVD, 32'hDEAD_BEEF);
    apb_read(A_RSVD, rd); chk("t5_rsvd_reads0", rd, 32'd0);

    // reset in the middle of a request
    apb_write(A_EVT_PEND, 32'h0000_0001);
    irq_sources_i[0] = 1'b1;
    step(1);
    irq_sources_i[0] = 1'b0;
    step(1);
    chk("t6_irq_o_pre", {31'd0, irq_o}, 32'd1);
    chk("t6_event_o_pre", {31'd0, event_o}, 32'd1);
    #2 HRESETn = 1'b0;
    #1;
    chk("t6_irq_o_async", {31'd0, irq_o}, 32'd0);
    chk("t6_irq_id_async", {27'd0, irq_id_o}, 32'd0);
    chk("t6_event_o_async", {31'd0, event_o}, 32'd0);
    step(2);
    HRESETn = 1'b1;
    step(1);
    apb_read(A_IRQ_MASK, rd); chk("t6_irq_mask0", rd, 32'd0);
    apb_read(A_IRQ_PEND, rd); chk("t6_irq_pend0", rd, 32'd0);
    apb_read(A_EVT_MASK, rd); chk("t6_evt_mask0", rd, 32'd0);
    apb_read(A_EVT_PEND, rd); chk("t6_evt_pend0", rd, 32'd0);
    chk("t6_irq_o_after", {31'd0, irq_o}, 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
